// File: rtl/fir_pkg.sv
// Shared types and width helper for the time-multiplexed FIR filter.
package fir_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } fir_state_e;

  // Result width large enough that TAPS worst-case products never overflow.
  function automatic int fir_out_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate; sum exposes acc + a*b for the final tap.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [OUT_W-1:0]  acc,
  output logic signed [OUT_W-1:0]  sum
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  prod_ext;
  logic signed [OUT_W-1:0]  acc_q;
  logic signed [OUT_W-1:0]  acc_d;

  assign prod     = a * b;
  assign prod_ext = {{(OUT_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign sum      = acc_q + prod_ext;
  assign acc      = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fir_seq_filter.sv
// Time-multiplexed signed FIR: one sample per go, one tap per clock through a shared MAC.
module fir_seq_filter
  import fir_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int COEF_W = 8,
  parameter  int TAPS   = 4,
  localparam int OUT_W  = fir_out_w(DATA_W, COEF_W, TAPS),
  localparam int IDX_W  = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] in,
  input  logic                     go,
  input  logic                     coef_we,
  input  logic [IDX_W-1:0]         coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     busy,
  output logic                     valid,
  output logic signed [OUT_W-1:0]  y
);

  fir_state_e state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     busy_q, busy_d;
  logic                     valid_q, valid_d;
  logic signed [OUT_W-1:0]  y_q, y_d;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [DATA_W-1:0] x_d [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];
  logic signed [COEF_W-1:0] c_d [TAPS];

  logic                     mac_clr;
  logic                     mac_en;
  logic signed [OUT_W-1:0]  mac_acc;
  logic signed [OUT_W-1:0]  mac_sum;

  fir_mac #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (mac_clr),
    .en   (mac_en),
    .a    (x_q[idx_q]),
    .b    (c_q[idx_q]),
    .acc  (mac_acc),
    .sum  (mac_sum)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    y_d     = y_q;
    x_d     = x_q;
    c_d     = c_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;

    case (state_q)
      IDLE: begin
        // Coefficient write lands on the accept edge, so a simultaneous go sees it from E1.
        if (coef_we && (int'(coef_addr) < TAPS)) begin
          c_d[coef_addr] = coef_data;
        end
        if (go) begin
          for (int k = TAPS - 1; k > 0; k--) begin
            x_d[k] = x_q[k-1];
          end
          x_d[0]  = in;
          mac_clr = 1'b1;
          idx_d   = '0;
          state_d = MAC;
          busy_d  = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (idx_q == IDX_W'(TAPS - 1)) begin
          y_d     = mac_sum;
          valid_d = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      y_q     <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= COEF_W'(1);
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      y_q     <= y_d;
      x_q     <= x_d;
      c_q     <= c_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign y     = y_q;

  logic unused_acc;
  assign unused_acc = ^mac_acc;

endmodule

// File: tb/tb_fir_seq_filter.sv
// Randomized bench for fir_seq_filter against a sum-of-products reference model.
module tb_fir_seq_filter;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 4;
  localparam int OUT_W  = DATA_W + COEF_W + $clog2(TAPS);

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic signed [DATA_W-1:0] in_s = '0;
  logic                     go = 1'b0;
  logic                     coef_we = 1'b0;
  logic [1:0]               coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic                     busy;
  logic                     valid;
  logic signed [OUT_W-1:0]  y;

  int checks = 0;
  int errors = 0;

  // Reference model: sample history (newest first) and coefficient table.
  int xm [TAPS];
  int cm [TAPS];

  fir_seq_filter #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .TAPS  (TAPS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in_s),
    .go       (go),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .busy     (busy),
    .valid    (valid),
    .y        (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_y();
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += xm[k] * cm[k];
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      xm[k] = 0;
      cm[k] = 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_y", y, 0);
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic write_coef(input int addr, input int data);
    coef_we   = 1'b1;
    coef_addr = 2'(addr);
    coef_data = COEF_W'(data);
    tick();
    coef_we   = 1'b0;
    cm[addr]  = data;
  endtask

  // Accepts one sample (optionally with a simultaneous coefficient write) and checks the result.
  task automatic send(input int sample, input bit with_we, input int we_addr, input int we_data,
                      input bit inject, output int result);
    int guard = 0;
    int n = 0;
    int exp;
    while (busy !== 1'b0 && guard < 50) begin
      tick();
      guard++;
    end
    if (busy !== 1'b0) check("idle_wait", busy, 0);
    if (with_we) begin
      coef_we   = 1'b1;
      coef_addr = 2'(we_addr);
      coef_data = COEF_W'(we_data);
      cm[we_addr] = we_data;
    end
    go   = 1'b1;
    in_s = DATA_W'(sample);
    tick();
    go      = 1'b0;
    coef_we = 1'b0;
    for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
    xm[0] = sample;
    exp = model_y();
    check("busy_after_go", busy, 1);
    while (n < 10) begin
      if (inject && n == 1) begin
        go        = 1'b1;
        in_s      = DATA_W'($urandom_range(0, 255));
        coef_we   = 1'b1;
        coef_addr = 2'($urandom_range(0, 3));
        coef_data = COEF_W'($urandom_range(0, 255));
      end
      tick();
      go      = 1'b0;
      coef_we = 1'b0;
      n++;
      if (valid === 1'b1) break;
      if (n < 4) check("no_early_valid", valid, 0);
    end
    check("latency", n, TAPS);
    check("y", y, exp);
    check("busy_done", busy, 0);
    tick();
    check("valid_pulse", valid, 0);
    check("y_hold", y, exp);
    $display("sample in=%0d y=%0d exp=%0d latency=%0d", sample, y, exp, n);
    result = exp;
  endtask

  initial begin
    int r;
    int seen;
    logic [OUT_W-1:0] ybits;
    model_reset();
    tick();
    do_reset();

    // Boxcar default.
    send(1, 0, 0, 0, 0, r); check("boxcar1", y, 1);
    send(2, 0, 0, 0, 0, r); check("boxcar2", y, 3);
    send(3, 0, 0, 0, 0, r); check("boxcar3", y, 6);
    send(4, 0, 0, 0, 0, r); check("boxcar4", y, 10);

    // Coefficient load.
    do_reset();
    write_coef(0, 1); write_coef(1, -1); write_coef(2, 2); write_coef(3, 0);
    send(5, 0, 0, 0, 0, r); check("coef_y1", y, 5);
    send(7, 0, 0, 0, 0, r); check("coef_y2", y, 2);

    // Signed extremes.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, -128);
    for (int k = 0; k < TAPS; k++) send(-128, 0, 0, 0, 0, r);
    check("extreme_max", y, 65536);
    do_reset();
    send(-1, 0, 0, 0, 0, r);
    ybits = y;
    check("neg_one_bits", ybits, 18'h3FFFF);

    // Busy ignore: mid-sequence go/coef_we must not disturb anything.
    do_reset();
    write_coef(1, 5);
    send(3, 0, 0, 0, 1, r);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (valid === 1'b1) seen++;
    end
    check("ignore_no_extra_valid", seen, 0);
    check("ignore_busy", busy, 0);
    send(4, 0, 0, 0, 0, r);
    send(0, 0, 0, 0, 0, r);

    // Simultaneous write and go.
    do_reset();
    send(2, 1, 0, 3, 0, r); check("simul_y", y, 6);

    // Reset mid-MAC.
    go = 1'b1; in_s = 8'sd50;
    tick();
    go = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("midrst_busy", busy, 0);
    check("midrst_y", y, 0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (valid === 1'b1) seen++;
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      if (valid === 1'b1) seen++;
    end
    check("midrst_no_valid", seen, 0);
    check("midrst_y_after", y, 0);
    send(9, 0, 0, 0, 0, r); check("midrst_next", y, 9);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int mode = int'($urandom_range(0, 3));
      if (mode == 0) write_coef(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128);
      send(int'($urandom_range(0, 255)) - 128, mode == 1, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)) - 128, mode == 2, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
